// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and defaults for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_e;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_REQ_DEF   = 4;
  localparam int BURST_MAX_DEF = 4;
  localparam int BURST_CNT_W   = 4;

  // Index width for a requester vector; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin pick: first set req bit after last_ptr
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               found
);

  always_comb begin
    int j;
    j          = 0;
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    // Scan last_ptr+1 .. last_ptr+NUM_REQ so the previous owner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = int'(last_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found      = 1'b1;
        winner[j]  = 1'b1;
        winner_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter in front of a FIFO write port
// Optional statistics counters (wr_count, stall_count) under FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      fifo_full,
  output logic                      insert,
  output logic [DATA_W-1:0]         data_in,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]               wr_count,
  output logic [15:0]               stall_count
`endif
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam logic [BURST_CNT_W-1:0] BURST_LAST = BURST_CNT_W'(BURST_MAX - 1);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       last_ptr_q, last_ptr_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic [NUM_REQ-1:0]     pick_onehot;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_found;
  logic                   owner_req;
  logic [DATA_W-1:0]      owner_data;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req        (req),
    .last_ptr   (last_ptr_q),
    .winner     (pick_onehot),
    .winner_idx (pick_idx),
    .found      (pick_found)
  );

  assign owner_req  = req[owner_q];
  assign owner_data = req_data[owner_q*DATA_W +: DATA_W];
  assign grant      = grant_q;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      last_ptr_q  <= PTR_RESET;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      last_ptr_q  <= last_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    last_ptr_d  = last_ptr_q;
    burst_cnt_d = burst_cnt_q;
    insert      = 1'b0;
    ack         = '0;
    data_in     = '0;
    busy        = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d = pick_onehot;
          owner_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (owner_req) begin
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      ST_XFER: begin
        // No write in a reset or flush cycle, nor once the owner has let go.
        insert = owner_req & ~fifo_full & ~flush & reset;
        if (insert) begin
          ack         = grant_q;
          data_in     = owner_data;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (!owner_req || (insert && (burst_cnt_q == BURST_LAST))) begin
          state_d     = ST_IDLE;
          grant_d     = '0;
          burst_cnt_d = '0;
          last_ptr_d  = owner_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = '0;
        burst_cnt_d = '0;
      end
    endcase

    if (flush) begin
      state_d     = ST_IDLE;
      grant_d     = '0;
      burst_cnt_d = '0;
      last_ptr_d  = last_ptr_q;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall_now;
  assign stall_now = (state_q == ST_XFER) && owner_req && fifo_full;

  always_ff @(posedge clk_in) begin
    if (!reset || flush) begin
      wr_count    <= '0;
      stall_count <= '0;
    end else begin
      if (insert)    wr_count    <= wr_count + 16'd1;
      if (stall_now) stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BM = 4;

  logic           clk_in = 1'b0;
  logic           reset, flush, fifo_full, insert, busy;
  logic [N-1:0]   req, ack, grant;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   data_in;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0]    wr_count, stall_count;
`endif

  always #5 clk_in = ~clk_in;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .BURST_MAX(BM)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .flush     (flush),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .insert    (insert),
    .data_in   (data_in),
    .ack       (ack),
    .grant     (grant),
    .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .wr_count    (wr_count),
    .stall_count (stall_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Producer-side word queues and the scoreboard's expected-word queues.
  logic [W-1:0] prod_q [N][$];
  logic [W-1:0] exp_q  [N][$];
  logic [N-1:0] seen_ack = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] rr_model(input logic [N-1:0] r, input int lo);
    logic [N-1:0] w;
    w = '0;
    for (int k = 1; k <= N; k++) begin
      if (r[(lo + k) % N]) begin
        w[(lo + k) % N] = 1'b1;
        return w;
      end
    end
    return w;
  endfunction

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += prod_q[i].size();
    return s;
  endfunction

  // Monitor: previous-cycle view used to predict this cycle's grant.
  logic         p_reset = 1'b0, p_flush = 1'b0, p_ins = 1'b0, p_full = 1'b0;
  logic [N-1:0] p_req = '0, p_grant = '0;
  int           p_age = 0, p_own = 0, words = 0, last_owner = N - 1;
  int           exp_wr = 0, exp_st = 0;

  always @(negedge clk_in) begin
    logic [N-1:0] eg;
    logic         ei;
    int           own, age;

    if (!p_reset) begin
      eg = '0;
      last_owner = N - 1;
    end else if (p_flush) begin
      eg = '0;
    end else if (p_grant == '0) begin
      eg = rr_model(p_req, last_owner);
    end else if (p_age == 1) begin
      eg = p_req[p_own] ? p_grant : '0;
    end else if (!p_req[p_own] || (p_ins && words == BM)) begin
      eg = '0;
      last_owner = p_own;
    end else begin
      eg = p_grant;
    end
    check("grant", grant, eg);
    check("grant_onehot0", $onehot0(grant), 1);

    if (grant != '0 && grant == p_grant) age = p_age + 1;
    else if (grant != '0)                age = 1;
    else                                 age = 0;
    own = idx_of(grant);
    if (age <= 1) words = 0;

    ei = reset && !flush && (age >= 2) && req[own] && !fifo_full;
    check("insert", insert, ei);
    check("ack", ack, ei ? grant : '0);
    check("busy", busy, grant != '0);
    if (grant == '0) check("data_idle", data_in, 0);
    if (insert) begin
      check("queue_nonempty", exp_q[own].size() != 0, 1);
      if (exp_q[own].size() != 0) check("data", data_in, exp_q[own].pop_front());
      words++;
    end

`ifdef FIFO_WR_ARB_STATS_EN
    if (!p_reset || p_flush) begin
      exp_wr = 0;
      exp_st = 0;
    end else begin
      exp_wr = (exp_wr + (p_ins ? 1 : 0)) & 16'hFFFF;
      exp_st = (exp_st + ((p_age >= 2 && p_req[p_own] && p_full) ? 1 : 0)) & 16'hFFFF;
    end
    check("wr_count", wr_count, exp_wr);
    check("stall_count", stall_count, exp_st);
`endif

    seen_ack = ack;
    p_reset  = reset;
    p_flush  = flush;
    p_ins    = insert;
    p_full   = fifo_full;
    p_req    = req;
    p_grant  = grant;
    p_age    = age;
    p_own    = own;
  end

  task automatic update_req();
    for (int i = 0; i < N; i++) begin
      req[i] = (prod_q[i].size() != 0);
      req_data[i*W +: W] = req[i] ? prod_q[i][0] : '0;
    end
  endtask

  task automatic tick(input logic fl, input logic full, input logic rst);
    @(posedge clk_in);
    #1;
    for (int i = 0; i < N; i++)
      if (seen_ack[i] && prod_q[i].size() != 0) void'(prod_q[i].pop_front());
    flush     = fl;
    fifo_full = full;
    reset     = rst;
    update_req();
  endtask

  task automatic add(input int i, input logic [W-1:0] d);
    prod_q[i].push_back(d);
    exp_q[i].push_back(d);
    update_req();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; fifo_full = 1'b0; req = '0; req_data = '0;
    repeat (3) tick(0, 0, 0);
    tick(0, 0, 1);

    // Lone requester 0
    add(0, 8'hA5); add(0, 8'h5A); add(0, 8'h3C); add(0, 8'hC3);
    repeat (10) tick(0, 0, 1);

    // All four requesting, more than one burst each
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 5; k++) add(i, 8'(i * 16 + k));
    repeat (40) tick(0, 0, 1);

    // Requester 2 stalled by a full FIFO mid-burst
    for (int k = 0; k < 4; k++) add(2, 8'(8'h20 + k));
    repeat (4) tick(0, 0, 1);
    repeat (5) tick(0, 1, 1);
    repeat (8) tick(0, 0, 1);

    // Requester 1 gives up after two words; 0 and 2 then compete
    add(1, 8'h11); add(1, 8'h12);
    repeat (2) tick(0, 0, 1);
    add(0, 8'h01); add(2, 8'h21);
    repeat (12) tick(0, 0, 1);

    // Flush mid-burst with requester 0 still holding
    for (int k = 0; k < 6; k++) add(0, 8'(8'h40 + k));
    repeat (4) tick(0, 0, 1);
    tick(1, 0, 1);
    repeat (14) tick(0, 0, 1);

    // Reset mid-burst on requester 3
    for (int k = 0; k < 4; k++) add(3, 8'(8'h70 + k));
    repeat (4) tick(0, 0, 1);
    tick(0, 0, 0);
    repeat (12) tick(0, 0, 1);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, N - 1));
      if (($urandom % 3) == 0 && prod_q[r].size() < 6) add(r, 8'($urandom));
      tick(($urandom % 50) == 0, ($urandom % 4) == 0, ($urandom % 400) != 0);
    end

    for (int c = 0; c < 300 && pending() > 0; c++) tick(0, 0, 1);
    check("drained", pending(), 0);
    repeat (3) tick(0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one 8-bit FIFO write port among NUM_REQ producers in a single clock domain.
- Selects one requester and grants it a bounded burst of writes.
- Drives the FIFO's insert/data_in, honours the FIFO's full flag, and gives each producer a per-word accept pulse.
- Sits directly in front of the FIFO write side.

Parameters:
- NUM_REQ, 4, number of producers (2..8)
- DATA_W, 8, word width; matches the FIFO data_in width
- BURST_MAX, 4, maximum words accepted per grant before re-arbitration (1..15)

Ports:
- clk_in  input  1  single clock; all logic on its rising edge
- reset  input  1  synchronous, active-low reset
- flush  input  1  synchronous abort; ends any grant, same cycle as FIFO flush
- req  input  NUM_REQ  per-producer request level; held while the producer has data
- req_data  input  NUM_REQ*DATA_W  producer words; requester i occupies bits [i*DATA_W +: DATA_W]
- fifo_full  input  1  FIFO full flag
- insert  output  1  FIFO write strobe; one word per cycle when high
- data_in  output  DATA_W  word to the FIFO; the granted requester's slice
- ack  output  NUM_REQ  one-hot pulse: the word of requester i is accepted this cycle
- grant  output  NUM_REQ  one-hot current owner; all zero when idle
- busy  output  1  high while in GRANT or XFER

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: sampled only at the rising edge of clk_in while reset=0.
  - Reset values: state=IDLE, grant=0, burst_cnt=0, last_ptr=NUM_REQ-1 (requester 0 has first priority).
  - Combinational outputs evaluate to insert=0, ack=0, data_in=0, busy=0 whenever state=IDLE.
- State machine (registered state, 2-bit encoding):
  - IDLE: if any req bit is set, register the winner into grant and go to GRANT. Otherwise stay.
  - GRANT: one-cycle settle; busy=1, no insert. Next state is XFER. If the owner's req has dropped, go to IDLE, with last_ptr unchanged.
  - XFER:
    - insert = req[owner] & ~fifo_full.
    - When insert=1: ack[owner]=1, data_in = owner's slice, burst_cnt increments.
    - When fifo_full=1: stall, with insert=0 and burst_cnt held. The state stays XFER indefinitely; there is no timeout.
    - Exit to IDLE when req[owner]=0, or when an insert occurs with burst_cnt==BURST_MAX-1.
    - On exit: last_ptr=owner, grant=0, burst_cnt=0.
- Winner selection:
  - First set req bit scanning upward from last_ptr+1, modulo NUM_REQ.
  - A lone requester wins repeatedly. Each burst costs 2 overhead cycles (IDLE, GRANT).
- Latency: req rising in IDLE gives the first insert 2 cycles later (IDLE→GRANT→XFER), provided the FIFO is not full.
- Throughput: 1 word/cycle inside a burst.
- Data mux:
  - data_in is a pure combinational select; no data is buffered in this block.
  - A producer must hold req_data stable until it sees ack.
- Simultaneous events:
  - flush has priority over everything except reset: next state IDLE, grant=0, burst_cnt=0, last_ptr unchanged. insert is forced to 0 in the flush cycle.
  - fifo_full and a req drop in the same cycle: the exit to IDLE wins and no word is written.
  - A req drop in XFER is seen combinationally, so no write occurs in that cycle.
- Reset mid-burst: the word in the reset cycle is not written (insert=0). The producer re-requests after reset.
- Invariants: grant is one-hot or zero; ack is a subset of grant; insert equals |ack.

Optional Feature:
- FIFO_WR_ARB_STATS_EN.
- Defined: adds output wr_count [15:0], which increments on every insert.
  - Wraps at 16'hFFFF to 0.
  - Cleared by reset or flush.
  - Also adds output stall_count [15:0], which increments every XFER cycle with req[owner]&fifo_full; same clear and wrap rules.
- Undefined: neither port exists and no counter logic is synthesised. All other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_GRANT=2'd1, ST_XFER=2'd2.
  - Default widths DATA_W_DEF=8, NUM_REQ_DEF=4.
  - BURST_CNT_W=4.
- One sub-module, rr_priority_pick: combinational, inputs req and last_ptr, output one-hot winner plus its index. It is reusable for the read-side arbiter.

Test Plan:
- Reset, then req=4'b0001 with data 8'hA5, FIFO empty → insert first high on the 3rd edge after req; ack=4'b0001 for 4 cycles; then back to IDLE; grant=0.
- req=4'b1111 held, BURST_MAX=4 → grant order 0,1,2,3,0; each owner gets exactly 4 acks; no cycle with insert=1 and two ack bits set.
- Requester 2 in XFER, fifo_full driven high for 5 cycles after the 2nd word → insert=0 for those 5 cycles, burst_cnt holds at 2, remaining 2 words written after full drops, then exit.
- Requester 1 drops req after 2 words → exactly 2 acks, IDLE next cycle, next winner is requester 2 (if requesting) rather than 0.
- flush asserted in XFER at word 3 → insert=0 in the flush cycle, grant=0 next cycle; with req=4'b0001 still high, requester 0 is regranted (last_ptr unchanged).
- FIFO_WR_ARB_STATS_EN build: 10 inserts and 3 stall cycles → wr_count=10, stall_count=3; reset=0 for one edge → both read 0.
